axi_write_arbiter: RTL and testbench
====================================

# axi_write_arbiter

- Shares one `axi_master_write_channel` instance between `NUM_REQ` DMA requesters.
- Arbitration is round-robin; one burst runs at a time.
- For the granted burst: latches that requester's address and length, issues a one-cycle `start` to the channel, routes the requester's async-FIFO read side to the channel, and waits for the channel's `done`.
- Sits between the DMA engines and the AXI write master.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 32: address width.
- `WRITE_CHANNEL_WIDTH`, 32: data beat width.
- `WRITE_BURST_LEN`, 8: length field width. Beats per burst = len+1.
- `WDOG_CYCLES`, 1024: watchdog limit. Used only when `AXI_WR_ARB_WDOG_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset. **Synchronous, active-high.**
- `req_valid` in NUM_REQ: per-requester burst request. Level-sensitive.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened. Requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_len` in NUM_REQ*WRITE_BURST_LEN: flattened, same slicing scheme.
- `req_done` out NUM_REQ: one-cycle completion pulse, one-hot.
- `req_afifo_rdata` in NUM_REQ*WRITE_CHANNEL_WIDTH: per-requester FIFO read data.
- `req_afifo_rempty` in NUM_REQ: per-requester FIFO empty.
- `req_afifo_rpull` out NUM_REQ: per-requester FIFO pop.
- `wr_start` out 1: to channel `start`.
- `wr_addr` out ADDR_WIDTH: to channel `target_write_addr`.
- `wr_burst_len` out WRITE_BURST_LEN: to channel `target_write_burst_len`.
- `wr_afifo_rdata` out WRITE_CHANNEL_WIDTH: to channel `dma2master_afifo_rdata`.
- `wr_afifo_rempty` out 1: to channel `dma2master_afifo_rempty`.
- `wr_afifo_rpull` in 1: from channel `dma2master_afifo_rpull`.
- `wr_done` in 1: from channel `done`.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out $clog2(NUM_REQ): current or last granted requester.
- `wdog_err` out 1: sticky watchdog error.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, FIN. Encodings come from the package.
- **IDLE:**
  - If any `req_valid` is high, pick the winner by round-robin, searching from `last_grant+1` with wrap-around.
  - Register `grant_id`, `wr_addr` and `wr_burst_len` from the winner's slices, then go to ISSUE.
- **ISSUE:** `wr_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** hold until `wr_done`=1, then go to FIN.
- **FIN:**
  - `req_done[grant_id]`=1 and `last_grant` <= `grant_id`.
  - Go to IDLE.
- **Address and length latching:** values are latched at grant. The requester may change them after `req_done`.
- **Request lifetime:** a requester keeps `req_valid` high until it sees `req_done`. If `req_valid` is still high in the cycle after `req_done`, that is a new request.
- **Data mux:** combinational, selected by the registered `grant_id`, in ISSUE/WAIT only.
  - `wr_afifo_rdata` = selected requester's `req_afifo_rdata`.
  - `wr_afifo_rempty` = selected requester's `req_afifo_rempty`. Forced to 1 in IDLE and FIN.
  - `req_afifo_rpull[i]` = `wr_afifo_rpull` && (ISSUE or WAIT) && `grant_id`==i.
- **Starvation:** with all requesters always valid, grants rotate 0,1,2,…,NUM_REQ-1,0,…
- **Simultaneous events:**
  - A `req_valid` that rises during ISSUE/WAIT/FIN is considered only at the next IDLE.
  - `wr_done` outside WAIT is ignored.
- **Reset mid-burst:**
  - All registers clear; any in-flight grant is dropped.
  - `rst` and the channel's `rst_n` are driven as complements of one source, so the channel aborts together with this block.

## Timing
- **Reset values:**
  - `wr_start`, `req_done`, `req_afifo_rpull`, `busy`, `wdog_err` = 0.
  - `grant_id` = 0; `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `wr_addr`, `wr_burst_len` = 0.
  - `wr_afifo_rempty` = 1; `wr_afifo_rdata` = 0.
- **Request to start:** `req_valid` sampled at edge t → ISSUE at t+1 → `wr_start` high during cycle t+1.
- **Done to completion:** `wr_done` at cycle d → `req_done` at d+1 → IDLE at d+2 → next `wr_start` no earlier than d+3.
  - This gap guarantees the channel has returned to its idle state before the next start.
- **FIFO pop path:** `wr_afifo_rpull` → `req_afifo_rpull` is zero-latency combinational.

## Configuration
- **Macro:** `AXI_WR_ARB_WDOG_EN`.
- **With the macro defined:**
  - A counter of $clog2(WDOG_CYCLES)+1 bits clears in IDLE and increments in ISSUE and WAIT.
  - When it reaches WDOG_CYCLES-1, `wdog_err` sets and stays set until `rst`.
  - The FSM is unaffected: no abort.
- **Without the macro:** no counter; `wdog_err` tied 0.

## Structure
- **Package `axi_wr_arb_pkg`:** holds the state encodings (ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_FIN=3) and the state width constant.
- **Sub-module `wr_rr_pick`:**
  - Combinational round-robin picker.
  - Inputs: `req` vector and `last_grant`. Outputs: `any` and `winner` index.
- **Top level:** holds the FSM, the latches, the mux and the watchdog.

## Test plan
- Only req 1 valid, addr 0x1000, len 3 → `wr_start` one cycle with `wr_addr`=0x1000 and `wr_burst_len`=3; channel makes 4 pulls, all on `req_afifo_rpull[1]`; `req_done`=0b0010 one cycle after `wr_done`.
- All 4 valid continuously → grant order 0,1,2,3,0; exactly one `wr_start` per `wr_done`; gap from `wr_done` to next `wr_start` ≥ 3 cycles.
- req 2 FIFO empty for 5 cycles mid-burst → `wr_afifo_rempty`=1, no pulls; burst resumes afterwards; other requesters' `req_afifo_rpull` stay 0.
- `rst`=1 during WAIT with req 3 granted → next cycle IDLE, all outputs at reset values, `wr_afifo_rempty`=1.
- req 0 changes addr after grant → `wr_addr` keeps the latched value.
- `AXI_WR_ARB_WDOG_EN` defined, WDOG_CYCLES=16, `wr_done` withheld → `wdog_err`=1 after 16 busy cycles and stays set after `wr_done`; without the macro it stays 0.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// Shared definitions for the AXI write-channel arbiter: FSM state encodings.
package axi_wr_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axi_write_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the last grant, wrapping around, and reports the first hit.
module wr_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  int idx;

  // Walk offsets 1..NUM_REQ from the last grant; the first requester found wins,
  // so the previous winner is considered last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write channel between NUM_REQ DMA requesters.
// One burst at a time: latch address/length at grant, pulse start, route the
// winner's FIFO read side to the channel, wait for done, then pulse req_done.
// Optional watchdog enabled by defining AXI_WR_ARB_WDOG_EN.
module axi_write_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8,
  parameter int WDOG_CYCLES         = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
  input  logic [NUM_REQ*WRITE_BURST_LEN-1:0]     req_len,
  output logic [NUM_REQ-1:0]                     req_done,
  input  logic [NUM_REQ*WRITE_CHANNEL_WIDTH-1:0] req_afifo_rdata,
  input  logic [NUM_REQ-1:0]                     req_afifo_rempty,
  output logic [NUM_REQ-1:0]                     req_afifo_rpull,
  output logic                                   wr_start,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [WRITE_BURST_LEN-1:0]             wr_burst_len,
  output logic [WRITE_CHANNEL_WIDTH-1:0]         wr_afifo_rdata,
  output logic                                   wr_afifo_rempty,
  input  logic                                   wr_afifo_rpull,
  input  logic                                   wr_done,
  output logic                                   busy,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id,
  output logic                                   wdog_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_param_check
    $error("axi_write_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES at least 2");
  end

  arb_state_e                 state_q, state_d;
  logic [ID_W-1:0]            grant_id_q, grant_id_d;
  logic [ID_W-1:0]            last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [WRITE_BURST_LEN-1:0] wr_burst_len_q, wr_burst_len_d;

  logic                       pick_any;
  logic [ID_W-1:0]            pick_winner;
  logic                       burst_active;

  logic [ADDR_WIDTH-1:0]          addr_arr  [NUM_REQ];
  logic [WRITE_BURST_LEN-1:0]     len_arr   [NUM_REQ];
  logic [WRITE_CHANNEL_WIDTH-1:0] rdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]   = req_len[i*WRITE_BURST_LEN +: WRITE_BURST_LEN];
    assign rdata_arr[i] = req_afifo_rdata[i*WRITE_CHANNEL_WIDTH +: WRITE_CHANNEL_WIDTH];
  end

  wr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  // State register plus grant/address/length latches; last_grant starts at the
  // top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      wr_addr_q      <= '0;
      wr_burst_len_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      wr_addr_q      <= wr_addr_d;
      wr_burst_len_q <= wr_burst_len_d;
    end
  end

  // Next-state logic: arbitrate only in IDLE, so requests arriving mid-burst wait.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    wr_addr_d      = wr_addr_q;
    wr_burst_len_d = wr_burst_len_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d        = ST_ISSUE;
          grant_id_d     = pick_winner;
          wr_addr_d      = addr_arr[pick_winner];
          wr_burst_len_d = len_arr[pick_winner];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wr_done) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        last_grant_d = grant_id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode and data mux; the FIFO path is only connected while a burst
  // is in flight, otherwise the channel sees an empty, silent FIFO.
  always_comb begin
    burst_active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    wr_start        = (state_q == ST_ISSUE);
    busy            = (state_q != ST_IDLE);
    req_done        = '0;
    req_afifo_rpull = '0;
    wr_afifo_rdata  = '0;
    wr_afifo_rempty = 1'b1;
    if (state_q == ST_FIN) begin
      req_done[grant_id_q] = 1'b1;
    end
    if (burst_active) begin
      wr_afifo_rdata              = rdata_arr[grant_id_q];
      wr_afifo_rempty             = req_afifo_rempty[grant_id_q];
      req_afifo_rpull[grant_id_q] = wr_afifo_rpull;
    end
  end

  assign grant_id     = grant_id_q;
  assign wr_addr      = wr_addr_q;
  assign wr_burst_len = wr_burst_len_q;

`ifdef AXI_WR_ARB_WDOG_EN
  localparam int              WDOG_W     = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  // Count cycles spent in ISSUE/WAIT, saturating at the limit; only flags, never aborts.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
    if (state_q == ST_IDLE) begin
      wdog_cnt_d = '0;
    end else if (burst_active) begin
      if (wdog_cnt_q == WDOG_LIMIT) begin
        wdog_err_d = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed testbench for axi_write_arbiter with NUM_REQ=4 and WDOG_CYCLES=16.
// Watchdog expectations follow AXI_WR_ARB_WDOG_EN.
module tb_axi_write_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [31:0]  req_len;
  logic [3:0]   req_done;
  logic [127:0] req_afifo_rdata;
  logic [3:0]   req_afifo_rempty;
  logic [3:0]   req_afifo_rpull;
  logic         wr_start;
  logic [31:0]  wr_addr;
  logic [7:0]   wr_burst_len;
  logic [31:0]  wr_afifo_rdata;
  logic         wr_afifo_rempty;
  logic         wr_afifo_rpull;
  logic         wr_done;
  logic         busy;
  logic [1:0]   grant_id;
  logic         wdog_err;

  int checks;
  int failures;

  axi_write_arbiter #(
    .NUM_REQ             (4),
    .ADDR_WIDTH          (32),
    .WRITE_CHANNEL_WIDTH (32),
    .WRITE_BURST_LEN     (8),
    .WDOG_CYCLES         (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_done         (req_done),
    .req_afifo_rdata  (req_afifo_rdata),
    .req_afifo_rempty (req_afifo_rempty),
    .req_afifo_rpull  (req_afifo_rpull),
    .wr_start         (wr_start),
    .wr_addr          (wr_addr),
    .wr_burst_len     (wr_burst_len),
    .wr_afifo_rdata   (wr_afifo_rdata),
    .wr_afifo_rempty  (wr_afifo_rempty),
    .wr_afifo_rpull   (wr_afifo_rpull),
    .wr_done          (wr_done),
    .busy             (busy),
    .grant_id         (grant_id),
    .wdog_err         (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    wr_done = 1'b0;
    wr_afifo_rpull = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    wr_afifo_rpull = 1'b1;
    tick();
    tick();
    #1;
    checks += 10;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (wr_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %b expected 0", wr_start); end
    if (req_done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_done: got %b expected 0000", req_done); end
    if (req_afifo_rpull !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rpull: got %b expected 0000", req_afifo_rpull); end
    if (wr_afifo_rempty !== 1'b1) begin failures++; $display("[TB] FAIL reset_rempty: got %b expected 1", wr_afifo_rempty); end
    if (wr_afifo_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", wr_afifo_rdata); end
    if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_grant: got %0d expected 0", grant_id); end
    if (wr_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", wr_addr); end
    if (wr_burst_len !== 8'h0) begin failures++; $display("[TB] FAIL reset_len: got %h expected 0", wr_burst_len); end
    if (wdog_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_wdog: got %b expected 0", wdog_err); end
    rst = 1'b0;
    req_valid = 4'b0000;
    wr_afifo_rpull = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_req_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_burst();
    int pulls;
    pulls = 0;
    req_addr[32 +: 32] = 32'h0000_1000;
    req_len[8 +: 8] = 8'd3;
    req_valid = 4'b0010;
    tick();
    checks += 4;
    if (wr_start !== 1'b1) begin failures++; $display("[TB] FAIL single_start: got %b expected 1", wr_start); end
    if (wr_addr !== 32'h0000_1000) begin failures++; $display("[TB] FAIL single_addr: got %h expected 00001000", wr_addr); end
    if (wr_burst_len !== 8'd3) begin failures++; $display("[TB] FAIL single_len: got %0d expected 3", wr_burst_len); end
    if (grant_id !== 2'd1) begin failures++; $display("[TB] FAIL single_grant: got %0d expected 1", grant_id); end
    tick();
    checks++;
    if (wr_start !== 1'b0) begin failures++; $display("[TB] FAIL single_start_one_cycle: got %b expected 0", wr_start); end
    for (int b = 0; b < 4; b++) begin
      wr_afifo_rpull = 1'b1;
      #1;
      if (req_afifo_rpull === 4'b0010) pulls++;
      if (b == 0) begin
        checks++;
        if (wr_afifo_rdata !== 32'hD0D0_0001) begin failures++; $display("[TB] FAIL single_rdata: got %h expected d0d00001", wr_afifo_rdata); end
      end
      tick();
    end
    wr_afifo_rpull = 1'b0;
    checks++;
    if (pulls != 4) begin failures++; $display("[TB] FAIL single_pulls: got %0d expected 4", pulls); end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    checks += 2;
    if (req_done !== 4'b0010) begin failures++; $display("[TB] FAIL single_req_done: got %b expected 0010", req_done); end
    if (wr_afifo_rempty !== 1'b1) begin failures++; $display("[TB] FAIL fin_rempty: got %b expected 1", wr_afifo_rempty); end
    req_valid = 4'b0000;
    tick();
    checks += 2;
    if (req_done !== 4'b0000) begin failures++; $display("[TB] FAIL single_done_one_cycle: got %b expected 0000", req_done); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_back_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int cnt;
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = 32'h100 * (i + 1);
      req_len[i*8 +: 8] = 8'(i);
    end
    req_valid = 4'hF;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      while (wr_start !== 1'b1 && cnt < 10) begin
        tick();
        cnt++;
      end
      checks += 3;
      if (wr_start !== 1'b1) begin failures++; $display("[TB] FAIL rr_start_timeout: burst %0d got no start", k); end
      if (grant_id !== 2'(g)) begin failures++; $display("[TB] FAIL rr_grant: burst %0d got %0d expected %0d", k, grant_id, g); end
      if (wr_addr !== 32'h100 * (g + 1)) begin failures++; $display("[TB] FAIL rr_addr: burst %0d got %h expected %h", k, wr_addr, 32'h100 * (g + 1)); end
      if (k > 0) begin
        checks++;
        if (cnt < 3) begin failures++; $display("[TB] FAIL rr_gap: burst %0d got %0d cycles expected >=3", k, cnt); end
      end
      tick();
      checks++;
      if (wr_start !== 1'b0) begin failures++; $display("[TB] FAIL rr_single_start: burst %0d got %b expected 0", k, wr_start); end
      tick();
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      #1;
      checks++;
      if (req_done !== 4'(1 << g)) begin failures++; $display("[TB] FAIL rr_req_done: burst %0d got %b expected %b", k, req_done, 4'(1 << g)); end
      if (k == 4) req_valid = 4'b0000;
      cnt = 1;
    end
    tick();
  endtask

  task automatic test_empty_stall();
    req_addr[64 +: 32] = 32'h0000_2000;
    req_len[16 +: 8] = 8'd7;
    req_afifo_rempty = 4'b0000;
    req_valid = 4'b0100;
    tick();
    checks++;
    if (grant_id !== 2'd2) begin failures++; $display("[TB] FAIL stall_grant: got %0d expected 2", grant_id); end
    tick();
    for (int b = 0; b < 2; b++) begin
      wr_afifo_rpull = 1'b1;
      #1;
      checks++;
      if (req_afifo_rpull !== 4'b0100) begin failures++; $display("[TB] FAIL stall_pre_pull: got %b expected 0100", req_afifo_rpull); end
      tick();
    end
    wr_afifo_rpull = 1'b0;
    req_afifo_rempty[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks += 2;
      if (wr_afifo_rempty !== 1'b1) begin failures++; $display("[TB] FAIL stall_rempty: cycle %0d got %b expected 1", c, wr_afifo_rempty); end
      if (req_afifo_rpull !== 4'b0000) begin failures++; $display("[TB] FAIL stall_no_pull: cycle %0d got %b expected 0000", c, req_afifo_rpull); end
      tick();
    end
    req_afifo_rempty[2] = 1'b0;
    #1;
    checks += 2;
    if (wr_afifo_rempty !== 1'b0) begin failures++; $display("[TB] FAIL stall_resume_rempty: got %b expected 0", wr_afifo_rempty); end
    if (wr_afifo_rdata !== 32'hD0D0_0002) begin failures++; $display("[TB] FAIL stall_rdata: got %h expected d0d00002", wr_afifo_rdata); end
    for (int b = 0; b < 6; b++) begin
      wr_afifo_rpull = 1'b1;
      #1;
      checks++;
      if (req_afifo_rpull !== 4'b0100) begin failures++; $display("[TB] FAIL stall_post_pull: beat %0d got %b expected 0100", b, req_afifo_rpull); end
      tick();
    end
    wr_afifo_rpull = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    checks++;
    if (req_done !== 4'b0100) begin failures++; $display("[TB] FAIL stall_req_done: got %b expected 0100", req_done); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_addr_latch();
    req_addr[0 +: 32] = 32'h0000_3000;
    req_len[0 +: 8] = 8'd5;
    req_valid = 4'b0001;
    tick();
    req_addr[0 +: 32] = 32'hDEAD_0000;
    req_len[0 +: 8] = 8'd9;
    tick();
    tick();
    checks += 2;
    if (wr_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL latch_addr: got %h expected 00003000", wr_addr); end
    if (wr_burst_len !== 8'd5) begin failures++; $display("[TB] FAIL latch_len: got %0d expected 5", wr_burst_len); end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    checks++;
    if (req_done !== 4'b0001) begin failures++; $display("[TB] FAIL latch_req_done: got %b expected 0001", req_done); end
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0001;
    tick();
    checks += 2;
    if (wr_addr !== 32'hDEAD_0000) begin failures++; $display("[TB] FAIL relatch_addr: got %h expected dead0000", wr_addr); end
    if (wr_burst_len !== 8'd9) begin failures++; $display("[TB] FAIL relatch_len: got %0d expected 9", wr_burst_len); end
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_ignore_done();
    wr_done = 1'b1;
    tick();
    tick();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_done_busy: got %b expected 0", busy); end
    if (req_done !== 4'b0000) begin failures++; $display("[TB] FAIL idle_done_req_done: got %b expected 0000", req_done); end
    wr_done = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b1000;
    tick();
    tick();
    checks += 2;
    if (grant_id !== 2'd3) begin failures++; $display("[TB] FAIL midrst_grant: got %0d expected 3", grant_id); end
    wr_afifo_rpull = 1'b1;
    #1;
    if (req_afifo_rpull !== 4'b1000) begin failures++; $display("[TB] FAIL midrst_pull_before: got %b expected 1000", req_afifo_rpull); end
    rst = 1'b1;
    tick();
    checks += 7;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL midrst_grant_clr: got %0d expected 0", grant_id); end
    if (wr_addr !== 32'h0) begin failures++; $display("[TB] FAIL midrst_addr: got %h expected 0", wr_addr); end
    if (wr_afifo_rempty !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rempty: got %b expected 1", wr_afifo_rempty); end
    if (wr_afifo_rdata !== 32'h0) begin failures++; $display("[TB] FAIL midrst_rdata: got %h expected 0", wr_afifo_rdata); end
    if (req_afifo_rpull !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_rpull: got %b expected 0000", req_afifo_rpull); end
    if (wr_start !== 1'b0 || req_done !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_pulses: got start %b done %b expected 0 0000", wr_start, req_done); end
    rst = 1'b0;
    req_valid = 4'b0000;
    wr_afifo_rpull = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after: got %b expected 0", busy); end
  endtask

  task automatic test_watchdog();
    logic exp_err;
`ifdef AXI_WR_ARB_WDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    req_valid = 4'b0010;
    tick();
    checks++;
    if (wdog_err !== 1'b0) begin failures++; $display("[TB] FAIL wdog_early: got %b expected 0", wdog_err); end
    for (int b = 2; b <= 20; b++) begin
      tick();
      if (b == 10) begin
        checks++;
        if (wdog_err !== 1'b0) begin failures++; $display("[TB] FAIL wdog_mid: got %b expected 0", wdog_err); end
      end
    end
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wdog_no_abort: got busy %b expected 1", busy); end
    if (wdog_err !== exp_err) begin failures++; $display("[TB] FAIL wdog_trip: got %b expected %b", wdog_err, exp_err); end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    req_valid = 4'b0000;
    tick();
    tick();
    checks++;
    if (wdog_err !== exp_err) begin failures++; $display("[TB] FAIL wdog_sticky: got %b expected %b", wdog_err, exp_err); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 4'b0000;
    req_addr = '0;
    req_len = '0;
    req_afifo_rempty = 4'b0000;
    wr_afifo_rpull = 1'b0;
    wr_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_afifo_rdata[i*32 +: 32] = 32'hD0D0_0000 + i;
    end
    test_reset();
    test_single_burst();
    test_round_robin();
    test_empty_stall();
    test_addr_latch();
    test_ignore_done();
    test_reset_mid_burst();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
